// File: rtl/img2col_feeder.sv
// Stream-side write controller for the img2col PU array: loads raster pixels band by
// band into the PUs, then sweeps every KERNEL x KERNEL window position for the MAC stage.
module img2col_feeder #(
  parameter int ROWS    = 28,
  parameter int ROW_LEN = 28,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int KERNEL  = 5,
  parameter int BANDS   = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              pu_start,
  output logic [5:0]        pu_no,
  output logic [5:0]        pu_round,
  output logic [DATA_W-1:0] pu_data,
  output logic [ADDR_W-1:0] pu_wr_adrs,
  output logic [ADDR_W-1:0] pu_rd_adrs,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] COL_LAST    = ADDR_W'(ROW_LEN - 1);
  localparam logic [ADDR_W-1:0] SW_COL_LAST = ADDR_W'(ROW_LEN - KERNEL);
  localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);
  localparam logic [5:0]        ROW_LAST    = 6'(ROWS - 1);
  localparam logic [5:0]        SW_ROW_LAST = 6'(ROWS - KERNEL);
  localparam logic [5:0]        BAND_LAST   = 6'(BANDS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic              pu_start_q, pu_start_d;
  logic [5:0]        pu_no_q, pu_no_d;
  logic [5:0]        pu_round_q, pu_round_d;
  logic [DATA_W-1:0] pu_data_q, pu_data_d;
  logic [ADDR_W-1:0] pu_wr_adrs_q, pu_wr_adrs_d;
  logic [ADDR_W-1:0] pu_rd_adrs_q, pu_rd_adrs_d;
  logic              win_valid_q, win_valid_d;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pu_start_d   = 1'b0;
    pu_no_d      = pu_no_q;
    pu_round_d   = pu_round_q;
    pu_data_d    = pu_data_q;
    pu_wr_adrs_d = pu_wr_adrs_q;
    pu_rd_adrs_d = pu_rd_adrs_q;
    win_valid_d  = win_valid_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d    = S_LOAD;
          pu_start_d = 1'b1;
          col_d      = '0;
          row_d      = '0;
          pu_round_d = '0;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          pu_data_d    = s_data;
          pu_wr_adrs_d = col_q;
          pu_no_d      = row_q;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + 6'd1;
            end
          end else begin
            col_d = col_q + ONE_A;
          end
        end
      end
      S_DRAIN: begin
        // The first DRAIN cycle still shows the final write; the sweep starts the cycle after.
        if (!win_valid_q) begin
          win_valid_d  = 1'b1;
          pu_no_d      = '0;
          pu_rd_adrs_d = '0;
        end else if (win_ready) begin
          if (pu_rd_adrs_q == SW_COL_LAST) begin
            pu_rd_adrs_d = '0;
            if (pu_no_q == SW_ROW_LAST) begin
              win_valid_d = 1'b0;
              if (pu_round_q == BAND_LAST) begin
                state_d = S_DONE;
              end else begin
                pu_round_d = pu_round_q + 6'd1;
                state_d    = S_LOAD;
              end
            end else begin
              pu_no_d = pu_no_q + 6'd1;
            end
          end else begin
            pu_rd_adrs_d = pu_rd_adrs_q + ONE_A;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      pu_start_q   <= 1'b0;
      pu_no_q      <= '0;
      pu_round_q   <= '0;
      pu_data_q    <= '0;
      pu_wr_adrs_q <= '0;
      pu_rd_adrs_q <= '0;
      win_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pu_start_q   <= pu_start_d;
      pu_no_q      <= pu_no_d;
      pu_round_q   <= pu_round_d;
      pu_data_q    <= pu_data_d;
      pu_wr_adrs_q <= pu_wr_adrs_d;
      pu_rd_adrs_q <= pu_rd_adrs_d;
      win_valid_q  <= win_valid_d;
    end
  end

  assign s_ready    = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign pu_start   = pu_start_q;
  assign pu_no      = pu_no_q;
  assign pu_round   = pu_round_q;
  assign pu_data    = pu_data_q;
  assign pu_wr_adrs = pu_wr_adrs_q;
  assign pu_rd_adrs = pu_rd_adrs_q;
  assign win_valid  = win_valid_q;

endmodule

// File: doc/img2col_feeder.md
Name: img2col_feeder

Overview:
Stream-side write controller for the img2col processing-unit (PU) array. It accepts a raster-ordered pixel stream with a valid/ready handshake and converts it into per-pixel PU select, write-address and data writes into the PU array. After each band is loaded, it sweeps PU select and read address across every convolution window position. Each window is presented to the downstream MAC stage with a valid/ready handshake.

Parameters:
ROWS, 28, number of PUs; image rows per band
ROW_LEN, 28, pixels per image row
DATA_W, 16, pixel width
ADDR_W, 5, PU register address width; must satisfy 2^ADDR_W >= ROW_LEN
KERNEL, 5, kernel edge; window is KERNEL x KERNEL taps
BANDS, 1, bands per frame; image height = ROWS*BANDS

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous reset, active-high (1 = reset)
frame_start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
s_data  in  DATA_W  pixel
s_valid  in  1  pixel valid
s_ready  out  1  feeder accepts pixel
pu_start  out  1  one-cycle pulse to PU array at frame begin
pu_no  out  6  PU select for write/read
pu_round  out  6  current band index
pu_data  out  DATA_W  write data to PU array
pu_wr_adrs  out  ADDR_W  PU write address (column)
pu_rd_adrs  out  ADDR_W  window base column
win_valid  out  1  window at (pu_no, pu_rd_adrs) is valid
win_ready  in  1  downstream consumes window
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset: all outputs 0; state IDLE; col, row, band and sweep counters 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - s_ready=0, win_valid=0.
  - frame_start=1 -> LOAD next cycle. pu_start=1 for exactly that one cycle. Counters cleared, pu_round=0.
- LOAD:
  - s_ready=1 combinationally.
  - Each accepted beat (s_valid&s_ready) registers, 1-cycle latency: pu_data<=s_data, pu_wr_adrs<=col, pu_no<=row.
  - Without a beat, pu_data, pu_wr_adrs and pu_no hold.
  - col increments per beat. At col==ROW_LEN-1: col wraps to 0, row++.
  - Beat with row==ROWS-1 and col==ROW_LEN-1: row->0, state->DRAIN.
- DRAIN:
  - s_ready=0.
  - Sweeps pu_no 0..ROWS-KERNEL (outer) and pu_rd_adrs 0..ROW_LEN-KERNEL (inner), presenting one window per position with win_valid=1.
  - Advances only on win_valid&win_ready. While win_ready=0, pu_no and pu_rd_adrs hold stable and win_valid stays 1.
  - After the last position (pu_no=ROWS-KERNEL, pu_rd_adrs=ROW_LEN-KERNEL) is accepted:
    - If pu_round==BANDS-1 -> DONE.
    - Else pu_round++ and -> LOAD.
  - Windows per band = (ROWS-KERNEL+1)*(ROW_LEN-KERNEL+1); 576 at defaults.
- DONE:
  - frame_done=1 for one cycle, then IDLE. pu_round holds its final value until the next frame_start.
- frame_start outside IDLE is ignored and has no side effects.
- s_valid in IDLE, DRAIN or DONE: no beat accepted, no state change.
- Reset asserted mid-frame: immediate return to reset values. A partially loaded band is discarded. No frame_done pulse.
- win_valid never rises in IDLE, LOAD or DONE. s_ready and win_valid are never 1 in the same cycle.
- Counter widths: all counters saturate-free by construction; compare against parameter bounds, never rely on natural wrap.

Test Plan:
- Reset, then frame_start, then 784 pixels with s_valid held high, value=index. Required:
  - 784 accepted beats.
  - Last write shows pu_no=27, pu_wr_adrs=27, pu_data=783.
  - DRAIN entered the following cycle.
- DRAIN with win_ready held high. Required:
  - Exactly 576 win_valid cycles; first (0,0), last (23,23).
  - frame_done pulses once, 1 cycle after the last acceptance.
  - busy falls the same cycle as the frame_done pulse ends.
- win_ready toggling 1,0,0,1 through DRAIN. Required:
  - pu_no and pu_rd_adrs stable during every stall.
  - Still exactly 576 accepted windows, none skipped or duplicated.
- s_valid random 50% in LOAD. Required:
  - pu_wr_adrs sequence 0..27 repeating, with pu_no stepping every 28 beats.
  - pu_data matches stimulus order.
- BANDS=2, two bands streamed. Required:
  - pu_round=0 for band 0 and 1 for band 1.
  - One pu_start pulse, one frame_done pulse.
  - 1152 windows total.
- Assert nrst after 300 beats, then release and issue frame_start. Required:
  - All outputs 0 during reset, no frame_done pulse.
  - Restarted frame begins at pu_no=0, pu_wr_adrs=0.
